// File: rtl/vx_tb_boot_sequencer_pkg.sv
// rtl/vx_tb_boot_sequencer_pkg.sv - shared boot-sequencer types and constants
// Boot-state encoding, DCR write record and default timing constants.
package vx_tb_boot_sequencer_pkg;

  localparam int VX_DCR_ADDR_WIDTH = 12;
  localparam int VX_DCR_DATA_WIDTH = 32;

  localparam int BOOT_DEFAULT_NUM_DCR_WRITES = 3;
  localparam int BOOT_DEFAULT_RESET_HOLD     = 8;
  localparam int BOOT_DEFAULT_LOAD_TIMEOUT   = 100000;

  typedef enum logic [2:0] {
    IDLE,
    RESET_HOLD,
    LOAD_START,
    LOAD_WAIT,
    DCR_WRITE,
    RELEASE,
    RUN,
    ERROR
  } boot_state_e;

  typedef struct packed {
    logic [VX_DCR_ADDR_WIDTH-1:0] addr;
    logic [VX_DCR_DATA_WIDTH-1:0] data;
  } dcr_wr_t;

endpackage

// File: rtl/vx_tb_dcr_writer.sv
// rtl/vx_tb_dcr_writer.sv - issues the startup DCR table as back-to-back writes
// A go pulse starts the burst; done is high during the final valid cycle.
module vx_tb_dcr_writer
  import vx_tb_boot_sequencer_pkg::*;
#(
  parameter int NUM_DCR_WRITES = BOOT_DEFAULT_NUM_DCR_WRITES
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        go,
  input  logic [NUM_DCR_WRITES*VX_DCR_ADDR_WIDTH-1:0] addr_tbl,
  input  logic [NUM_DCR_WRITES*VX_DCR_DATA_WIDTH-1:0] data_tbl,
  output logic                                        valid,
  output logic [VX_DCR_ADDR_WIDTH-1:0]                addr,
  output logic [VX_DCR_DATA_WIDTH-1:0]                data,
  output logic                                        done
);

  localparam int AW    = VX_DCR_ADDR_WIDTH;
  localparam int DW    = VX_DCR_DATA_WIDTH;
  localparam int IDX_W = $clog2(NUM_DCR_WRITES + 1);
  localparam logic [IDX_W-1:0] END_IDX = IDX_W'(NUM_DCR_WRITES);

  // idx points at the next entry to load; it reaches END_IDX during the last write
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] sel;
  dcr_wr_t          entry;

  always_comb begin
    sel   = go ? '0 : idx;
    entry = '0;
    if (sel != END_IDX) begin
      entry.addr = addr_tbl[int'(sel)*AW +: AW];
      entry.data = data_tbl[int'(sel)*DW +: DW];
    end
  end

  assign done = valid && (idx == END_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
      idx   <= '0;
    end else if (go) begin
      valid <= 1'b1;
      addr  <= entry.addr;
      data  <= entry.data;
      idx   <= IDX_W'(1);
    end else if (valid) begin
      if (idx == END_IDX) begin
        valid <= 1'b0;
        addr  <= '0;
        data  <= '0;
        idx   <= '0;
      end else begin
        addr <= entry.addr;
        data <= entry.data;
        idx  <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_tb_boot_sequencer.sv
// rtl/vx_tb_boot_sequencer.sv - brings the GPU out of reset: hold, load, DCR setup, release
// Optional loader timeout enabled by defining VX_BOOT_TIMEOUT_EN.
module vx_tb_boot_sequencer
  import vx_tb_boot_sequencer_pkg::*;
#(
  parameter int NUM_DCR_WRITES      = BOOT_DEFAULT_NUM_DCR_WRITES,
  parameter int RESET_HOLD_CYCLES   = BOOT_DEFAULT_RESET_HOLD,
  parameter int LOAD_TIMEOUT_CYCLES = BOOT_DEFAULT_LOAD_TIMEOUT
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        start,
  input  logic [NUM_DCR_WRITES*VX_DCR_ADDR_WIDTH-1:0] dcr_addr_tbl,
  input  logic [NUM_DCR_WRITES*VX_DCR_DATA_WIDTH-1:0] dcr_data_tbl,
  input  logic                                        mem_loader_done,
  input  logic                                        core_busy,
  output logic                                        mem_load_reset,
  output logic                                        mem_reset,
  output logic                                        mem_arb_reset,
  output logic                                        icache_reset,
  output logic                                        dcache_reset,
  output logic                                        gbar_reset,
  output logic                                        core_reset,
  output logic                                        start_mem_loader,
  output logic                                        dcr_write_valid,
  output logic [VX_DCR_ADDR_WIDTH-1:0]                dcr_write_addr,
  output logic [VX_DCR_DATA_WIDTH-1:0]                dcr_write_data,
  output logic                                        boot_done,
  output logic                                        timeout_err
);

  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  boot_state_e      state, next_state;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic             armed;
  logic             wr_go, wr_done;
  logic             mem_rst_q, cache_rst_q, core_rst_q;
  logic             mem_rel_d, cache_rel_d, core_rel_d;
  logic             unused_core_busy;

  assign unused_core_busy = core_busy;

`ifdef VX_BOOT_TIMEOUT_EN
  localparam logic [31:0] LOAD_LAST = 32'(LOAD_TIMEOUT_CYCLES - 1);
  logic [31:0] load_cnt;
  logic        timeout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_cnt <= '0;
    end else if (state == LOAD_WAIT) begin
      load_cnt <= load_cnt + 32'd1;
    end else begin
      load_cnt <= '0;
    end
  end
`else
  logic [31:0] unused_timeout_limit;
  assign unused_timeout_limit = 32'(LOAD_TIMEOUT_CYCLES);
`endif

  always_comb begin
    next_state = state;
    hold_cnt_d = hold_cnt;
    wr_go      = 1'b0;
    case (state)
      IDLE: begin
        hold_cnt_d = '0;
        if (start && armed) next_state = RESET_HOLD;
      end
      RESET_HOLD: begin
        if (hold_cnt == HOLD_LAST) next_state = LOAD_START;
        else                       hold_cnt_d = hold_cnt + 1'b1;
      end
      LOAD_START: next_state = LOAD_WAIT;
      LOAD_WAIT: begin
        if (mem_loader_done) begin
          next_state = DCR_WRITE;
          wr_go      = 1'b1;
        end
`ifdef VX_BOOT_TIMEOUT_EN
        else if (load_cnt == LOAD_LAST) begin
          next_state = ERROR;
        end
`endif
      end
      DCR_WRITE: if (wr_done) next_state = RELEASE;
      RELEASE:   next_state = RUN;
      RUN:       next_state = RUN;
      ERROR:     next_state = ERROR;
      default:   next_state = IDLE;
    endcase
  end

  // Reset outputs are registered from next_state so they line up with the state they belong to
  always_comb begin
    mem_rel_d   = ((next_state == RESET_HOLD) && (hold_cnt_d == HOLD_LAST)) ||
                  (next_state inside {LOAD_START, LOAD_WAIT, DCR_WRITE, RELEASE, RUN});
    cache_rel_d = next_state inside {DCR_WRITE, RELEASE, RUN};
    core_rel_d  = next_state inside {RELEASE, RUN};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      hold_cnt         <= '0;
      armed            <= 1'b0;
      mem_rst_q        <= 1'b1;
      cache_rst_q      <= 1'b1;
      core_rst_q       <= 1'b1;
      start_mem_loader <= 1'b0;
      boot_done        <= 1'b0;
    end else begin
      state            <= next_state;
      hold_cnt         <= hold_cnt_d;
      armed            <= 1'b1;
      mem_rst_q        <= !mem_rel_d;
      cache_rst_q      <= !cache_rel_d;
      core_rst_q       <= !core_rel_d;
      start_mem_loader <= (next_state == LOAD_START);
      boot_done        <= core_rel_d;
    end
  end

`ifdef VX_BOOT_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) timeout_q <= 1'b0;
    else          timeout_q <= (next_state == ERROR);
  end
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign mem_load_reset = mem_rst_q;
  assign mem_reset      = mem_rst_q;
  assign mem_arb_reset  = mem_rst_q;
  assign icache_reset   = cache_rst_q;
  assign dcache_reset   = cache_rst_q;
  assign gbar_reset     = cache_rst_q;
  assign core_reset     = core_rst_q;

  vx_tb_dcr_writer #(
    .NUM_DCR_WRITES(NUM_DCR_WRITES)
  ) u_dcr_writer (
    .clk      (clk),
    .reset_n  (reset_n),
    .go       (wr_go),
    .addr_tbl (dcr_addr_tbl),
    .data_tbl (dcr_data_tbl),
    .valid    (dcr_write_valid),
    .addr     (dcr_write_addr),
    .data     (dcr_write_data),
    .done     (wr_done)
  );

endmodule

// File: tb/tb_vx_tb_boot_sequencer.sv
// tb/tb_vx_tb_boot_sequencer.sv - directed bench for the boot sequencer
// Expected timeout behaviour follows VX_BOOT_TIMEOUT_EN.
module tb_vx_tb_boot_sequencer;

`ifdef VX_BOOT_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, start, mem_loader_done, core_busy;
  logic [35:0] addr_tbl;
  logic [95:0] data_tbl;
  logic        mem_load_reset, mem_reset, mem_arb_reset, icache_reset;
  logic        dcache_reset, gbar_reset, core_reset, start_mem_loader;
  logic        dcr_write_valid, boot_done, timeout_err;
  logic [11:0] dcr_write_addr;
  logic [31:0] dcr_write_data;
  logic [6:0]  rsts;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign rsts = {mem_load_reset, mem_reset, mem_arb_reset, icache_reset,
                 dcache_reset, gbar_reset, core_reset};

  vx_tb_boot_sequencer #(
    .NUM_DCR_WRITES(3),
    .RESET_HOLD_CYCLES(8),
    .LOAD_TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .dcr_addr_tbl(addr_tbl), .dcr_data_tbl(data_tbl),
    .mem_loader_done(mem_loader_done), .core_busy(core_busy),
    .mem_load_reset(mem_load_reset), .mem_reset(mem_reset), .mem_arb_reset(mem_arb_reset),
    .icache_reset(icache_reset), .dcache_reset(dcache_reset), .gbar_reset(gbar_reset),
    .core_reset(core_reset), .start_mem_loader(start_mem_loader),
    .dcr_write_valid(dcr_write_valid), .dcr_write_addr(dcr_write_addr),
    .dcr_write_data(dcr_write_data), .boot_done(boot_done), .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; mem_loader_done = 1'b0; core_busy = 1'b0;
    addr_tbl = {12'h003, 12'h002, 12'h001};
    data_tbl = {32'h0000_0001, 32'h0000_0000, 32'h8000_0000};
    tick(); tick();
    check("rst_resets", {57'd0, rsts}, 64'h7F);
    check("rst_load_pulse", {63'd0, start_mem_loader}, 64'd0);
    check("rst_valid", {63'd0, dcr_write_valid}, 64'd0);
    check("rst_addr", {52'd0, dcr_write_addr}, 64'd0);
    check("rst_data", {32'd0, dcr_write_data}, 64'd0);
    check("rst_boot_done", {63'd0, boot_done}, 64'd0);
    check("rst_timeout", {63'd0, timeout_err}, 64'd0);

    // start coincident with reset release must be ignored
    reset_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("start_at_release_ignored", {57'd0, rsts}, 64'h7F);

    // boot 1
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    check("hold_mid_resets", {57'd0, rsts}, 64'h7F);
    tick();
    check("hold_last_mem_rel", {57'd0, rsts}, 64'h0F);
    check("hold_last_no_pulse", {63'd0, start_mem_loader}, 64'd0);
    tick();
    check("load_pulse", {63'd0, start_mem_loader}, 64'd1);
    check("load_start_resets", {57'd0, rsts}, 64'h0F);
    tick();
    check("load_pulse_single", {63'd0, start_mem_loader}, 64'd0);
    repeat (19) tick();
    check("wait_no_valid", {63'd0, dcr_write_valid}, 64'd0);
    mem_loader_done = 1'b1;
    tick();
    check("w0_valid", {63'd0, dcr_write_valid}, 64'd1);
    check("w0_addr", {52'd0, dcr_write_addr}, 64'h001);
    check("w0_data", {32'd0, dcr_write_data}, 64'h8000_0000);
    check("w0_resets", {57'd0, rsts}, 64'h01);
    tick();
    check("w1_addr", {52'd0, dcr_write_addr}, 64'h002);
    check("w1_data", {32'd0, dcr_write_data}, 64'h0);
    tick();
    check("w2_valid", {63'd0, dcr_write_valid}, 64'd1);
    check("w2_addr", {52'd0, dcr_write_addr}, 64'h003);
    check("w2_data", {32'd0, dcr_write_data}, 64'h1);
    tick();
    check("rel_valid", {63'd0, dcr_write_valid}, 64'd0);
    check("rel_addr", {52'd0, dcr_write_addr}, 64'd0);
    check("rel_resets", {57'd0, rsts}, 64'h00);
    check("rel_boot_done", {63'd0, boot_done}, 64'd1);
    mem_loader_done = 1'b0;

    // start pulses while running change nothing
    repeat (3) begin
      start = 1'b1; tick(); start = 1'b0; tick();
    end
    check("run_resets", {57'd0, rsts}, 64'h00);
    check("run_boot_done", {63'd0, boot_done}, 64'd1);
    check("run_no_pulse", {63'd0, start_mem_loader}, 64'd0);
    check("run_no_valid", {63'd0, dcr_write_valid}, 64'd0);

    // boot 2: loader done already high, reset mid-write
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick(); tick();
    mem_loader_done = 1'b1;
    addr_tbl = {12'h7FF, 12'h011, 12'h010};
    data_tbl = {32'hFFFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF};
    start = 1'b1; tick(); start = 1'b0;
    repeat (8) tick();
    check("pre_done_load_pulse", {63'd0, start_mem_loader}, 64'd1);
    tick();
    check("pre_done_single_pulse", {63'd0, start_mem_loader}, 64'd0);
    check("pre_done_wait_valid", {63'd0, dcr_write_valid}, 64'd0);
    tick();
    check("pre_done_w0_addr", {52'd0, dcr_write_addr}, 64'h010);
    check("pre_done_w0_data", {32'd0, dcr_write_data}, 64'hDEAD_BEEF);
    tick();
    check("pre_done_w1_addr", {52'd0, dcr_write_addr}, 64'h011);
    #2 reset_n = 1'b0;
    #1;
    check("abort_valid", {63'd0, dcr_write_valid}, 64'd0);
    check("abort_addr", {52'd0, dcr_write_addr}, 64'd0);
    check("abort_resets", {57'd0, rsts}, 64'h7F);
    check("abort_boot_done", {63'd0, boot_done}, 64'd0);
    reset_n = 1'b1; mem_loader_done = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (9) tick();
    mem_loader_done = 1'b1;
    tick();
    check("rerun_w0_addr", {52'd0, dcr_write_addr}, 64'h010);
    repeat (3) tick();
    check("rerun_boot_done", {63'd0, boot_done}, 64'd1);
    check("rerun_resets", {57'd0, rsts}, 64'h00);

    // loader never finishes
    reset_n = 1'b0; mem_loader_done = 1'b0; tick(); reset_n = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (9) tick();
    repeat (49) tick();
    check("to_before_limit", {63'd0, timeout_err}, 64'd0);
    tick();
    check("to_flag", {63'd0, timeout_err}, {63'd0, TO_EN});
    check("to_resets", {57'd0, rsts}, TO_EN ? 64'h7F : 64'h0F);
    check("to_no_valid", {63'd0, dcr_write_valid}, 64'd0);
    mem_loader_done = 1'b1;
    tick();
    check("to_late_done_valid", {63'd0, dcr_write_valid}, {63'd0, !TO_EN});
    check("to_flag_sticky", {63'd0, timeout_err}, {63'd0, TO_EN});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vx_tb_boot_sequencer.md
Name: vx_tb_boot_sequencer

Overview:
Drives the testbench-top control signals that bring the GPU out of reset. It holds all sub-block resets, starts the memory loader and waits for it to finish, then issues the startup DCR writes. It then releases the core reset and reports boot completion to the UVM test layer. It feeds the tb-top interface (resets, loader start) and the DCR write interface.

Parameters:
NUM_DCR_WRITES, 3, number of startup DCR writes (1..16)
RESET_HOLD_CYCLES, 8, cycles all resets are held after start (>=1)
LOAD_TIMEOUT_CYCLES, 100000, loader timeout limit (used only with the optional feature)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle boot request; honoured only in IDLE
dcr_addr_tbl  in  NUM_DCR_WRITES x VX_DCR_ADDR_WIDTH  DCR write addresses, issued in index order
dcr_data_tbl  in  NUM_DCR_WRITES x VX_DCR_DATA_WIDTH  DCR write data
mem_loader_done  in  1  loader completion level
core_busy  in  1  core activity level
mem_load_reset, mem_reset, mem_arb_reset, icache_reset, dcache_reset, gbar_reset, core_reset  out  1 each  active-high sub-block resets
start_mem_loader  out  1  single-cycle loader start pulse
dcr_write_valid  out  1  DCR write strobe
dcr_write_addr  out  VX_DCR_ADDR_WIDTH  DCR address
dcr_write_data  out  VX_DCR_DATA_WIDTH  DCR data
boot_done  out  1  high once the core is released
timeout_err  out  1  sticky loader-timeout flag

Behaviour:
- Async reset (reset_n=0):
  - state=IDLE.
  - All seven resets=1.
  - start_mem_loader=0, dcr_write_valid=0, dcr_write_addr=0, dcr_write_data=0.
  - boot_done=0, timeout_err=0.
- All outputs are registered; no combinational input-to-output paths.
- IDLE: resets held at 1. start=1 -> RESET_HOLD, hold counter cleared.
- RESET_HOLD:
  - Counts RESET_HOLD_CYCLES cycles.
  - On the last count: mem_reset, mem_arb_reset and mem_load_reset go to 0 together; go to LOAD_START.
- LOAD_START: start_mem_loader=1 for exactly this one cycle; go to LOAD_WAIT.
- LOAD_WAIT: waits for mem_loader_done=1.
  - mem_loader_done already high on the first LOAD_WAIT cycle is accepted.
  - On done: icache_reset, dcache_reset and gbar_reset go to 0 together; go to DCR_WRITE with index 0.
- DCR_WRITE:
  - One write per cycle: dcr_write_valid=1 with addr/data from table[index]; index increments each cycle.
  - Exactly NUM_DCR_WRITES consecutive valid cycles, then valid=0, addr/data return to 0; go to RELEASE.
  - The index counter is sized $clog2(NUM_DCR_WRITES+1) and never wraps.
- RELEASE: core_reset=0 and boot_done=1 in the same cycle; go to RUN.
- RUN:
  - Stays in RUN; core_busy is ignored for state.
  - start is ignored in every non-IDLE state. Re-boot requires reset_n.
- Simultaneous events: start arriving in the same cycle reset_n deasserts is ignored. The first honoured start comes the cycle after reset release.
- Reset mid-operation: any state returns to IDLE immediately with all resets re-asserted. A DCR write in progress is abandoned (valid drops asynchronously).
- ERROR: all resets re-asserted, timeout_err=1 sticky, no further writes. Reachable only with the optional feature.

Optional Feature:
VX_BOOT_TIMEOUT_EN
- Defined:
  - A 32-bit counter runs in LOAD_WAIT.
  - If LOAD_TIMEOUT_CYCLES cycles elapse without mem_loader_done: go to ERROR, timeout_err=1.
  - done arriving on the same cycle as the timeout wins (no error).
- Undefined: no counter, LOAD_WAIT waits forever, timeout_err is tied 0.

Decomposition:
- Shared package (VX_gpu_pkg side, tb section):
  - boot-state enum: IDLE, RESET_HOLD, LOAD_START, LOAD_WAIT, DCR_WRITE, RELEASE, RUN, ERROR.
  - DCR write struct {addr, data}.
  - Default hold and timeout constants.
- One natural sub-module: vx_tb_dcr_writer. It takes a go pulse and the table, emits the sequential DCR writes, and returns a done pulse.

Test Plan:
- Reset, start pulse -> after 8 cycles mem resets=0; next cycle start_mem_loader high 1 cycle; other resets still 1.
- mem_loader_done after 20 cycles, table {(0x001,0x80000000),(0x002,0x0),(0x003,0x1)} -> three consecutive valid cycles with exactly those pairs; the next cycle core_reset=0, boot_done=1.
- mem_loader_done held high before LOAD_WAIT -> accepted on the first LOAD_WAIT cycle; no extra start_mem_loader pulse.
- reset_n pulsed low during the second DCR write -> dcr_write_valid=0 at once, all resets=1, boot_done=0; a new start reruns the full sequence.
- With VX_BOOT_TIMEOUT_EN, LOAD_TIMEOUT_CYCLES=50, done never asserted -> timeout_err=1 at cycle 50 of LOAD_WAIT, all resets=1, no DCR writes.
- Repeated start pulses in RUN -> no output changes.
